scr1_imem_responder: RTL and testbench

SCR1_IMEM_RESPONDER -- requirements
Module: scr1_imem_responder

---
 rtl/scr1_imem_responder_pkg.sv | 25 ++
 rtl/scr1_imem_responder.sv | 96 +++++++++
 tb/tb_scr1_imem_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/scr1_imem_responder_pkg.sv
// Shared memory-interface types for the instruction-memory responder: command and
// response encodings plus the bus-width defaults used by the port lists.
`ifndef SCR1_IMEM_AWIDTH
`define SCR1_IMEM_AWIDTH 32
`endif
`ifndef SCR1_IMEM_DWIDTH
`define SCR1_IMEM_DWIDTH 32
`endif

package scr1_imem_responder_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    localparam int SCR1_RESP_WAIT_MAX = 15;

endpackage

// File: rtl/scr1_imem_responder.sv
// Instruction-memory responder over an external sync RAM; response SCR1_RESP_WAIT+1 cycles
// after accept, one-cycle response; accepts only in IDLE or on a good response (no queueing).
module scr1_imem_responder
    import scr1_imem_responder_pkg::*;
#(
    parameter logic [`SCR1_IMEM_AWIDTH-1:0] SCR1_ADDR_MASK    = `SCR1_IMEM_AWIDTH'hFFFF0000,
    parameter logic [`SCR1_IMEM_AWIDTH-1:0] SCR1_ADDR_PATTERN = `SCR1_IMEM_AWIDTH'h00010000,
    parameter int                           SCR1_RESP_WAIT    = 0,
    parameter int                           SCR1_RAM_AWIDTH   = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           imem_req,
    output logic                           imem_req_ack,
    input  type_scr1_mem_cmd_e             imem_cmd,
    input  logic [`SCR1_IMEM_AWIDTH-1:0]   imem_addr,
    output logic [`SCR1_IMEM_DWIDTH-1:0]   imem_rdata,
    output type_scr1_mem_resp_e            imem_resp,
    output logic                           mem_rd_en,
    output logic [SCR1_RAM_AWIDTH-1:0]     mem_rd_addr,
    input  logic [`SCR1_IMEM_DWIDTH-1:0]   mem_rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam bit         NO_WAIT   = (SCR1_RESP_WAIT == 0);
    localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(SCR1_RESP_WAIT - 1);

    state_e                     state;
    logic [3:0]                 cnt;
    logic                       err_r;
    logic [SCR1_RAM_AWIDTH-1:0] addr_r;

    logic resp_ok;
    logic accept;
    logic req_err;
    logic wait_done;

    assign resp_ok   = (state == ST_RESP) && !err_r;
    // Gated by rst_n so the initiator never sees an ack while the block is held in reset.
    assign imem_req_ack = rst_n && ((state == ST_IDLE) || resp_ok);
    assign accept    = imem_req && imem_req_ack;
    assign req_err   = (imem_cmd != SCR1_MEM_CMD_RD) || (imem_addr[1:0] != 2'b00)
                    || ((imem_addr & SCR1_ADDR_MASK) != SCR1_ADDR_PATTERN);
    assign wait_done = (state == ST_WAIT) && (cnt == 4'd0);

    assign mem_rd_en   = (accept && NO_WAIT && !req_err) || (wait_done && !err_r);
    assign mem_rd_addr = (state == ST_WAIT) ? addr_r : imem_addr[SCR1_RAM_AWIDTH+1:2];

    assign imem_resp  = (state != ST_RESP) ? SCR1_MEM_RESP_NOTRDY
                      : (err_r ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK);
    assign imem_rdata = resp_ok ? mem_rd_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            err_r  <= 1'b0;
            addr_r <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        err_r  <= req_err;
                        addr_r <= imem_addr[SCR1_RAM_AWIDTH+1:2];
                        if (NO_WAIT) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always @(posedge clk) begin
        assert (SCR1_RESP_WAIT >= 0 && SCR1_RESP_WAIT <= SCR1_RESP_WAIT_MAX);
        if (rst_n && imem_req) begin
            assert (!$isunknown({imem_cmd, imem_addr}));
        end
    end

endmodule

// File: tb/tb_scr1_imem_responder.sv
// Bench for scr1_imem_responder: four instances with wait counts 0..3 sharing one RAM image.
module tb_scr1_imem_responder;
    import scr1_imem_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n   [4];
    logic                req     [4];
    logic                ack     [4];
    type_scr1_mem_cmd_e  cmd     [4];
    logic [31:0]         addr    [4];
    logic [31:0]         rdata   [4];
    type_scr1_mem_resp_e resp    [4];
    logic                rd_en   [4];
    logic [9:0]          rd_addr [4];
    logic [31:0]         ram     [1024];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic [31:0] rdq;
        scr1_imem_responder #(.SCR1_RESP_WAIT(g)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[g]),
            .imem_req     (req[g]),
            .imem_req_ack (ack[g]),
            .imem_cmd     (cmd[g]),
            .imem_addr    (addr[g]),
            .imem_rdata   (rdata[g]),
            .imem_resp    (resp[g]),
            .mem_rd_en    (rd_en[g]),
            .mem_rd_addr  (rd_addr[g]),
            .mem_rd_data  (rdq)
        );
        always @(posedge clk) if (rd_en[g]) rdq <= ram[rd_addr[g]];
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (wait=%0d): got %h expected %h", name, k, act, exp);
        end
    endtask

    // Reference: a good read is an aligned RD inside the 64 KiB window at 0x10000.
    function automatic void model(input type_scr1_mem_cmd_e c, input logic [31:0] a,
                                  output type_scr1_mem_resp_e r, output logic [31:0] d);
        bit good = (c == SCR1_MEM_CMD_RD) && (a % 4 == 0) && (a >= 32'h0001_0000) && (a < 32'h0002_0000);
        r = good ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER;
        d = good ? ram[(a / 4) % 1024] : 32'h0;
    endfunction

    function automatic type_scr1_mem_cmd_e rand_cmd();
        return ($urandom_range(0, 4) == 0) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
    endfunction

    // Called and returns in the drive phase (just after a rising edge).
    task automatic do_xfer(input int k, input type_scr1_mem_cmd_e c, input logic [31:0] a,
                           output int acc_wait, output int lat, output type_scr1_mem_resp_e r,
                           output logic [31:0] d, output int n_rd, output logic [9:0] rda,
                           output logic ack_resp, output logic ack_next, output type_scr1_mem_resp_e r_next);
        acc_wait = 0; lat = -1; r = SCR1_MEM_RESP_NOTRDY; d = '0; n_rd = 0; rda = '0;
        ack_resp = 1'b0; ack_next = 1'b0; r_next = SCR1_MEM_RESP_NOTRDY;
        cmd[k] = c; addr[k] = a; req[k] = 1'b1;
        @(negedge clk);
        while (!ack[k] && acc_wait < 20) begin
            acc_wait++;
            @(negedge clk);
        end
        if (rd_en[k]) begin n_rd++; rda = rd_addr[k]; end
        @(posedge clk); #1;
        req[k] = 1'b0; addr[k] = $urandom; cmd[k] = rand_cmd();
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rd_en[k]) begin n_rd++; rda = rd_addr[k]; end
            if (resp[k] != SCR1_MEM_RESP_NOTRDY) begin
                lat = i; r = resp[k]; d = rdata[k]; ack_resp = ack[k];
                break;
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        ack_next = ack[k]; r_next = resp[k];
        @(posedge clk); #1;
    endtask

    task automatic run_and_check(input string tag, input int k, input type_scr1_mem_cmd_e c,
                                 input logic [31:0] a, input type_scr1_mem_resp_e er, input logic [31:0] ed);
        int acc_wait, lat, n_rd;
        type_scr1_mem_resp_e r, r_next;
        logic [31:0] d;
        logic [9:0] rda;
        logic ack_resp, ack_next;
        bit good = (er == SCR1_MEM_RESP_RDY_OK);
        do_xfer(k, c, a, acc_wait, lat, r, d, n_rd, rda, ack_resp, ack_next, r_next);
        chk({tag, " accept_wait"}, k, acc_wait, 0);
        chk({tag, " latency"}, k, lat, k + 1);
        chk({tag, " resp"}, k, r, er);
        chk({tag, " rdata"}, k, d, ed);
        chk({tag, " ram_reads"}, k, n_rd, good ? 1 : 0);
        if (good) chk({tag, " rd_addr"}, k, rda, a[11:2]);
        chk({tag, " ack_in_resp"}, k, ack_resp, good);
        chk({tag, " ack_after"}, k, ack_next, 1'b1);
        chk({tag, " resp_after"}, k, r_next, SCR1_MEM_RESP_NOTRDY);
    endtask

    typedef struct {
        int                  k;
        type_scr1_mem_cmd_e  cmd;
        logic [31:0]         addr;
        type_scr1_mem_resp_e resp;
        logic [31:0]         rdata;
    } vec_t;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [8];
        for (int k = 0; k < 4; k++) begin
            rst_n[k] = 1'b0; req[k] = 1'b1; cmd[k] = SCR1_MEM_CMD_RD; addr[k] = 32'h0001_0000;
        end
        for (int i = 0; i < 1024; i++) ram[i] = 32'h5A00_0000 ^ (i * 32'h0001_0307);
        ram[1] = 32'hDEAD_BEEF;

        // Reset: requests are asserted but must not be acknowledged.
        @(negedge clk); @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("reset ack", k, ack[k], 1'b0);
            chk("reset resp", k, resp[k], SCR1_MEM_RESP_NOTRDY);
            chk("reset rdata", k, rdata[k], 32'h0);
            chk("reset rd_en", k, rd_en[k], 1'b0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin rst_n[k] = 1'b1; req[k] = 1'b0; end
        @(posedge clk); #1;

        tbl[0] = '{0, SCR1_MEM_CMD_RD, 32'h0001_0004, SCR1_MEM_RESP_RDY_OK, 32'hDEAD_BEEF};
        tbl[1] = '{0, SCR1_MEM_CMD_RD, 32'h0001_0002, SCR1_MEM_RESP_RDY_ER, 32'h0};
        tbl[2] = '{0, SCR1_MEM_CMD_WR, 32'h0001_0000, SCR1_MEM_RESP_RDY_ER, 32'h0};
        tbl[3] = '{2, SCR1_MEM_CMD_RD, 32'h0002_0000, SCR1_MEM_RESP_RDY_ER, 32'h0};
        tbl[4] = '{1, SCR1_MEM_CMD_RD, 32'h0001_0010, SCR1_MEM_RESP_RDY_OK, ram[4]};
        tbl[5] = '{3, SCR1_MEM_CMD_RD, 32'h0001_FFFC, SCR1_MEM_RESP_RDY_OK, ram[1023]};
        tbl[6] = '{2, SCR1_MEM_CMD_RD, 32'h0001_0008, SCR1_MEM_RESP_RDY_OK, ram[2]};
        tbl[7] = '{1, SCR1_MEM_CMD_RD, 32'hFFFF_0000, SCR1_MEM_RESP_RDY_ER, 32'h0};
        for (int i = 0; i < 8; i++)
            run_and_check($sformatf("vec%0d", i), tbl[i].k, tbl[i].cmd, tbl[i].addr, tbl[i].resp, tbl[i].rdata);

        // Back-to-back on wait=2: second accept lands in the first response cycle.
        cmd[2] = SCR1_MEM_CMD_RD; addr[2] = 32'h0001_0000; req[2] = 1'b1;
        @(negedge clk);
        chk("b2b first ack", 2, ack[2], 1'b1);
        @(posedge clk); #1;
        addr[2] = 32'h0001_0008;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("b2b rd_en t+%0d", c), 2, rd_en[2], (c == 2 || c == 5));
            if (c == 2) chk("b2b rd_addr t+2", 2, rd_addr[2], 10'd0);
            if (c == 5) chk("b2b rd_addr t+5", 2, rd_addr[2], 10'd2);
            if (c == 3) begin
                chk("b2b resp t+3", 2, resp[2], SCR1_MEM_RESP_RDY_OK);
                chk("b2b rdata t+3", 2, rdata[2], ram[0]);
                chk("b2b ack t+3", 2, ack[2], 1'b1);
            end else if (c == 6) begin
                chk("b2b resp t+6", 2, resp[2], SCR1_MEM_RESP_RDY_OK);
                chk("b2b rdata t+6", 2, rdata[2], ram[2]);
            end else begin
                chk($sformatf("b2b resp t+%0d", c), 2, resp[2], SCR1_MEM_RESP_NOTRDY);
            end
            @(posedge clk); #1;
            if (c == 3) req[2] = 1'b0;
        end

        // Reset pulse on wait=3 in the cycle after accept drops the transfer.
        cmd[3] = SCR1_MEM_CMD_RD; addr[3] = 32'h0001_0000; req[3] = 1'b1;
        @(negedge clk);
        chk("rst accept", 3, ack[3], 1'b1);
        chk("rst resp at accept", 3, resp[3], SCR1_MEM_RESP_NOTRDY);
        @(posedge clk); #1;
        req[3] = 1'b0; rst_n[3] = 1'b0;
        @(negedge clk);
        chk("rst mid resp", 3, resp[3], SCR1_MEM_RESP_NOTRDY);
        chk("rst mid ack", 3, ack[3], 1'b0);
        chk("rst mid rd_en", 3, rd_en[3], 1'b0);
        chk("rst mid rdata", 3, rdata[3], 32'h0);
        @(posedge clk); #1;
        rst_n[3] = 1'b1;
        run_and_check("after_rst", 3, SCR1_MEM_CMD_RD, 32'h0001_0004, SCR1_MEM_RESP_RDY_OK, ram[1]);

        // Randomized transfers against the reference model.
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 15; n++) begin
                logic [31:0] a;
                type_scr1_mem_cmd_e c;
                type_scr1_mem_resp_e er;
                logic [31:0] ed;
                case ($urandom_range(0, 3))
                    0, 1:    a = {16'h0001, 14'($urandom), 2'b00};
                    2:       a = {16'h0001, 14'($urandom), 2'($urandom_range(1, 3))};
                    default: a = $urandom;
                endcase
                c = rand_cmd();
                model(c, a, er, ed);
                run_and_check($sformatf("rnd%0d", n), k, c, a, er, ed);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
